// File: rtl/l2_cache_ctrl_nway.sv
// l2_cache_ctrl_nway: control FSM for an N-way write-back L2 cache.
// Sits between the L2 arbiter and physical memory. It sequences hit service,
// dirty-victim write-back and line fill, and drives the per-way array write
// strobes, the LRU update and the datapath mux selects.
// Build option L2_PREFETCH_EN: after each demand miss fill, prefetch the next
// PREF_DEPTH lines. A demand request seen in PCHECK aborts the remaining
// prefetch.
module l2_cache_ctrl_nway #(
  parameter int WAYS       = 4,
  parameter int PREF_DEPTH = 1,
  localparam int WIDX      = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  output logic            mem_resp,
  output logic            pmem_read,
  output logic            pmem_write,
  input  logic            pmem_resp,
  input  logic            hit,
  input  logic [WAYS-1:0] hit_way,
  input  logic [WAYS-1:0] repl_way,
  input  logic            dirty,
  output logic [WAYS-1:0] wr_valid,
  output logic [WAYS-1:0] wr_tag,
  output logic [WAYS-1:0] wr_data,
  output logic [WAYS-1:0] wr_dirty,
  output logic            dirty_in,
  output logic            wr_lru,
  output logic            din_sel,
  output logic            addr_sel,
  output logic            pref_sel,
  output logic [2:0]      pref_idx,
  output logic [WIDX-1:0] dout_sel
);

`ifdef L2_PREFETCH_EN
  typedef enum logic [3:0] {
    S_IDLE, S_COMPARE, S_WB, S_ALLOC,
    S_PCHECK, S_PWB, S_PALLOC, S_PDONE, S_ADVANCE
  } state_t;
  localparam logic [2:0] PREF_LAST = 3'(PREF_DEPTH);
  logic       pref_pending_reg;
  logic [2:0] pref_idx_reg;
`else
  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_WB, S_ALLOC} state_t;
  // PREF_DEPTH has no effect when prefetch is compiled out
  logic [2:0] unused_pref_depth;
  assign unused_pref_depth = 3'(PREF_DEPTH);
`endif

  state_t state_reg;

  // Read wins when both request lines are raised
  logic req;
  logic is_write;
  assign req      = mem_read | mem_write;
  assign is_write = mem_write & ~mem_read;

  // One-hot to index; lowest set bit wins for a malformed vector
  function automatic logic [WIDX-1:0] enc(input logic [WAYS-1:0] v);
    enc = '0;
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (v[i]) enc = WIDX'(i);
    end
  endfunction

  logic [WIDX-1:0] hit_enc;
  logic [WIDX-1:0] repl_enc;
  assign hit_enc  = enc(hit_way);
  assign repl_enc = enc(repl_way);

  // State register plus prefetch bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
`ifdef L2_PREFETCH_EN
      pref_pending_reg <= 1'b0;
      pref_idx_reg     <= 3'd0;
`endif
    end else begin
      case (state_reg)
        S_IDLE:    if (req) state_reg <= S_COMPARE;
        S_COMPARE: begin
          if (hit) begin
`ifdef L2_PREFETCH_EN
            if (pref_pending_reg) begin
              pref_idx_reg <= 3'd1;
              state_reg    <= S_PCHECK;
            end else begin
              state_reg <= S_IDLE;
            end
`else
            state_reg <= S_IDLE;
`endif
          end else if (dirty) begin
            state_reg <= S_WB;
          end else begin
            state_reg <= S_ALLOC;
          end
        end
        S_WB:      if (pmem_resp) state_reg <= S_ALLOC;
        S_ALLOC: begin
          if (pmem_resp) begin
`ifdef L2_PREFETCH_EN
            pref_pending_reg <= 1'b1;
`endif
            state_reg <= S_COMPARE;
          end
        end
`ifdef L2_PREFETCH_EN
        S_PCHECK: begin
          if (req) begin
            pref_pending_reg <= 1'b0;
            pref_idx_reg     <= 3'd0;
            state_reg        <= S_IDLE;
          end else if (hit) begin
            state_reg <= S_ADVANCE;
          end else if (dirty) begin
            state_reg <= S_PWB;
          end else begin
            state_reg <= S_PALLOC;
          end
        end
        S_PWB:     if (pmem_resp) state_reg <= S_PALLOC;
        S_PALLOC:  if (pmem_resp) state_reg <= S_PDONE;
        S_PDONE:   state_reg <= S_ADVANCE;
        S_ADVANCE: begin
          if (pref_idx_reg == PREF_LAST) begin
            pref_pending_reg <= 1'b0;
            pref_idx_reg     <= 3'd0;
            state_reg        <= S_IDLE;
          end else begin
            pref_idx_reg <= pref_idx_reg + 3'd1;
            state_reg    <= S_PCHECK;
          end
        end
`endif
        default:   state_reg <= S_IDLE;
      endcase
    end
  end

`ifdef L2_PREFETCH_EN
  assign pref_idx = pref_idx_reg;
`else
  assign pref_idx = 3'd0;
`endif

  // Output decode from the state register; hit service needs the same-cycle hit
  always_comb begin
    mem_resp   = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    wr_valid   = '0;
    wr_tag     = '0;
    wr_data    = '0;
    wr_dirty   = '0;
    dirty_in   = 1'b0;
    wr_lru     = 1'b0;
    din_sel    = 1'b0;
    addr_sel   = 1'b0;
    pref_sel   = 1'b0;
    dout_sel   = hit_enc;
    case (state_reg)
      S_COMPARE: begin
        if (hit) begin
          mem_resp = 1'b1;
          wr_lru   = 1'b1;
          if (is_write) begin
            din_sel  = 1'b1;
            wr_data  = hit_way;
            wr_dirty = hit_way;
            dirty_in = 1'b1;
          end
        end
      end
      S_WB: begin
        addr_sel   = 1'b1;
        dout_sel   = repl_enc;
        pmem_write = 1'b1;
      end
      S_ALLOC: begin
        pmem_read = 1'b1;
        wr_valid  = repl_way;
        wr_tag    = repl_way;
        wr_data   = repl_way;
        wr_dirty  = repl_way;
      end
`ifdef L2_PREFETCH_EN
      S_PCHECK, S_ADVANCE: pref_sel = 1'b1;
      S_PWB: begin
        pref_sel   = 1'b1;
        addr_sel   = 1'b1;
        dout_sel   = repl_enc;
        pmem_write = 1'b1;
      end
      S_PALLOC: begin
        pref_sel  = 1'b1;
        pmem_read = 1'b1;
        wr_valid  = repl_way;
        wr_tag    = repl_way;
        wr_data   = repl_way;
        wr_dirty  = repl_way;
      end
      S_PDONE: begin
        pref_sel = 1'b1;
        wr_lru   = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule
